// File: rtl/actbuf_wr_ctrl.sv
// actbuf_wr_ctrl: ping-pong activation buffer write controller.
// Streams incoming beats into one of two banks, tracks per-bank full flags,
// and waits for the consumer to release a bank before refilling it.
// Optional feature: define ACTBUF_WR_DROP_CHK_EN to enable the sticky
// dropped-beat flag on wr_drop_err (tied to 0 otherwise).
module actbuf_wr_ctrl #(
    parameter int ACTBUF_DATA_LEN  = 16,
    parameter int ACTBUF_ADDRM_LEN = 9
) (
    input  logic                          clk_l,
    input  logic                          rst,
    input  logic                          sblk_param_en,
    input  logic [ACTBUF_ADDRM_LEN-1:0]   addr_max,
    input  logic [2*ACTBUF_DATA_LEN-1:0]  actbuf_wr_data,
    input  logic                          actbuf_wr_vld,
    output logic                          actbuf_wr_req,
    input  logic [1:0]                    buf_rd_done,
    output logic [1:0]                    mem_wr_en,
    output logic [ACTBUF_ADDRM_LEN-1:0]   mem_wr_addr,
    output logic [2*ACTBUF_DATA_LEN-1:0]  mem_wr_data,
    output logic [1:0]                    bank_full,
    output logic                          fill_done,
    output logic                          wr_drop_err
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT_BANK} state_t;

    state_t                      state, state_nxt;
    logic                        bank;
    logic [ACTBUF_ADDRM_LEN-1:0] addr;
    logic [ACTBUF_ADDRM_LEN-1:0] cur_max;
    logic [ACTBUF_ADDRM_LEN-1:0] shadow;
    logic                        accept;
    logic                        complete;
    logic [1:0]                  full_nxt;

    // State register
    always_ff @(posedge clk_l) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, handshake and bank-full update; the post-toggle decision
    // looks at the new bank's next full value so a same-cycle release counts
    always_comb begin
        actbuf_wr_req = (state == REQ) || (state == FILL);
        accept        = actbuf_wr_req && actbuf_wr_vld;
        complete      = accept && (addr == cur_max);
        full_nxt      = (bank_full & ~buf_rd_done) | (complete ? (bank ? 2'b10 : 2'b01) : 2'b00);
        state_nxt     = state;
        case (state)
            IDLE:      state_nxt = sblk_param_en ? REQ : IDLE;
            REQ, FILL: if (accept) state_nxt = !complete ? FILL : (full_nxt[~bank] ? WAIT_BANK : REQ);
            WAIT_BANK: state_nxt = bank_full[bank] ? WAIT_BANK : REQ;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bank select, address counter and bound registers; a new bound only
    // takes effect at a bank toggle so a bank is never cut short mid-fill
    always_ff @(posedge clk_l) begin
        if (rst) begin
            bank    <= 1'b0;
            addr    <= '0;
            cur_max <= '0;
            shadow  <= '0;
        end else if (state == IDLE) begin
            if (sblk_param_en) begin
                bank    <= 1'b0;
                addr    <= '0;
                cur_max <= addr_max;
                shadow  <= addr_max;
            end
        end else begin
            if (complete) begin
                bank    <= ~bank;
                addr    <= '0;
                cur_max <= shadow;
            end else if (accept) begin
                addr    <= addr + 1'b1;
            end
            if (sblk_param_en) shadow <= addr_max;
        end
    end

    // Registered bank write port plus completion flags
    always_ff @(posedge clk_l) begin
        if (rst) begin
            mem_wr_en   <= 2'b00;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            bank_full   <= 2'b00;
            fill_done   <= 1'b0;
        end else begin
            mem_wr_en   <= accept ? (bank ? 2'b10 : 2'b01) : 2'b00;
            mem_wr_addr <= accept ? addr : mem_wr_addr;
            mem_wr_data <= accept ? actbuf_wr_data : mem_wr_data;
            bank_full   <= full_nxt;
            fill_done   <= complete;
        end
    end

`ifdef ACTBUF_WR_DROP_CHK_EN
    // Sticky flag for beats offered while not ready
    always_ff @(posedge clk_l) begin
        if (rst)                                 wr_drop_err <= 1'b0;
        else if (actbuf_wr_vld && !actbuf_wr_req) wr_drop_err <= 1'b1;
    end
`else
    assign wr_drop_err = 1'b0;
`endif

endmodule
